nabp_line_sequencer: RTL and testbench
======================================

Name: nabp_line_sequencer

Overview:
Top-level sequencer for the NABP shifter/mapper datapath. On a host kick it walks every projection angle and, for each angle, every image line: fetches the angle's fixed-point accumulator step from the angle LUT, then issues fill and shift kicks to the shifter and waits for its done pulses. It also applies downstream back-pressure and reports completion to the host.

Parameters:
IMAGE_SIZE, 128, lines per angle (one fill+shift pass per line)
NO_OF_ANGLES, 180, projection angles per frame
ANGLE_WIDTH, 8, width of angle index, >= clog2(NO_OF_ANGLES)
LINE_WIDTH, 7, width of line index, >= clog2(IMAGE_SIZE)
ACCU_WIDTH, 16, width of fixed-point accumulator step (same format as shifter sc_accu_base)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
hs_kick  in  1  host start pulse; ignored unless idle
hs_busy  out  1  high from accepted kick until hs_done
hs_done  out  1  one-cycle pulse after last line of last angle
lut_angle  out  ANGLE_WIDTH  angle index to angle LUT
lut_accu_base  in  ACCU_WIDTH  LUT data, valid 1 cycle after lut_angle changes
sh_fill_kick  out  1  one-cycle fill start to shifter
sh_shift_kick  out  1  one-cycle shift start to shifter
sh_accu_base  out  ACCU_WIDTH  registered step, held stable for the whole angle
sh_fill_done  in  1  shifter fill-complete pulse
sh_shift_done  in  1  shifter shift-complete pulse
ds_stall  in  1  downstream back-pressure; blocks the next shift kick
angle  out  ANGLE_WIDTH  current angle index
line  out  LINE_WIDTH  current line index
angle_kick  out  1  one-cycle pulse at start of each angle (PE accumulator reset)

Behaviour:
- Reset (asynchronous, reset_n low): state READY; all kick/done pulses 0; hs_busy 0; angle, line, lut_angle 0; sh_accu_base 0.
- States: READY, LOOKUP, LATCH, FILL, FILL_WAIT, SHIFT_ARM, SHIFT_WAIT, ADVANCE, DONE.
- READY: on hs_kick, set angle=0, line=0, lut_angle=0, hs_busy=1, go to LOOKUP.
- LOOKUP: one cycle for LUT latency, then LATCH.
- LATCH: sh_accu_base <= lut_accu_base; angle_kick=1 this cycle; go to FILL.
- FILL: sh_fill_kick=1 for exactly one cycle; go to FILL_WAIT.
- FILL_WAIT: wait for sh_fill_done, then SHIFT_ARM. A done pulse arriving in any other state is ignored.
- SHIFT_ARM: if ds_stall=0, sh_shift_kick=1 for one cycle and go to SHIFT_WAIT; otherwise hold with no kick. Stall is sampled only here; a stall raised mid-shift does not abort the shift.
- SHIFT_WAIT: on sh_shift_done go to ADVANCE.
- ADVANCE:
  - if line != IMAGE_SIZE-1: line+1, go to FILL (same angle, no LUT fetch).
  - else if angle != NO_OF_ANGLES-1: line=0, angle+1, lut_angle=angle+1, go to LOOKUP.
  - else go to DONE.
- DONE: hs_done=1 for one cycle, hs_busy=0, return to READY.
- Counters wrap only through explicit reset to 0; they never overflow.
- hs_kick while busy is ignored; it is not queued.
- Minimum cycles per line, excluding shifter time: FILL, FILL_WAIT(>=1), SHIFT_ARM, SHIFT_WAIT(>=1), ADVANCE. Per-angle overhead: LOOKUP + LATCH = 2 cycles.
- Simultaneous sh_fill_done and sh_shift_done: only the one expected by the current state is acted on.
- All outputs are registered or decoded from state only (Moore); no combinational path from inputs to kicks.
- sh_accu_base changes only in LATCH, never between a fill kick and the following shift done.

Decomposition:
- Shared package/defines: state encoding, parameter defaults (IMAGE_SIZE, NO_OF_ANGLES, ACCU_WIDTH), and the fixed-point format of the accumulator step, shared with the shifter and the angle LUT generator.
- Natural sub-module: nabp_line_sequencer_counters (angle/line counters with last-flags).
- FSM stays in the top.

Test Plan:
- IMAGE_SIZE=4, NO_OF_ANGLES=3, shifter model done after 5 cycles; hs_kick -> exactly 12 fill kicks and 12 shift kicks, angle_kick x3, hs_done once, hs_busy low after hs_done.
- LUT returns 16'h0100+angle -> sh_accu_base = 0100/0101/0102, each stable across its 4 lines.
- ds_stall high 10 cycles after a fill done -> no shift kick during stall; kick in the cycle after stall drops; sequence completes.
- Spurious sh_shift_done during FILL_WAIT -> ignored; state stays FILL_WAIT until sh_fill_done.
- hs_kick pulsed again mid-frame -> ignored; total kicks unchanged.
- reset_n low mid-SHIFT_WAIT (angle 1, line 2) -> immediate READY, all outputs 0; a new hs_kick restarts at angle 0, line 0.

Source files
------------

// File: rtl/nabp_line_sequencer_pkg.sv
// ============================================================================
// nabp_line_sequencer_pkg : shared state encoding, defaults, step format
// Revision: 1.0
// ============================================================================
`default_nettype none

package nabp_line_sequencer_pkg;

    localparam int c_image_size_default   = 128;
    localparam int c_no_of_angles_default = 180;
    localparam int c_angle_width_default  = 8;
    localparam int c_line_width_default   = 7;
    localparam int c_accu_width_default   = 16;

    // Accumulator step is unsigned Q8.8, identical to the shifter's sc_accu_base
    localparam int c_accu_frac_bits = 8;

    localparam int c_state_width = 4;

    localparam logic [3:0] c_st_ready      = 4'd0;
    localparam logic [3:0] c_st_lookup     = 4'd1;
    localparam logic [3:0] c_st_latch      = 4'd2;
    localparam logic [3:0] c_st_fill       = 4'd3;
    localparam logic [3:0] c_st_fill_wait  = 4'd4;
    localparam logic [3:0] c_st_shift_arm  = 4'd5;
    localparam logic [3:0] c_st_shift_wait = 4'd6;
    localparam logic [3:0] c_st_advance    = 4'd7;
    localparam logic [3:0] c_st_done       = 4'd8;

endpackage

`default_nettype wire

// File: rtl/nabp_line_sequencer_counters.sv
// ============================================================================
// nabp_line_sequencer_counters : angle/line counters with last-value flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module nabp_line_sequencer_counters
    import nabp_line_sequencer_pkg::*;
#(
    parameter int IMAGE_SIZE   = c_image_size_default,
    parameter int NO_OF_ANGLES = c_no_of_angles_default,
    parameter int ANGLE_WIDTH  = c_angle_width_default,
    parameter int LINE_WIDTH   = c_line_width_default
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   line_inc,
    input  logic                   angle_inc,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic [LINE_WIDTH-1:0]  line,
    output logic                   line_last,
    output logic                   angle_last
);

    localparam logic [LINE_WIDTH-1:0]  c_line_last  = LINE_WIDTH'(IMAGE_SIZE - 1);
    localparam logic [ANGLE_WIDTH-1:0] c_angle_last = ANGLE_WIDTH'(NO_OF_ANGLES - 1);

    logic [ANGLE_WIDTH-1:0] r_angle;
    logic [LINE_WIDTH-1:0]  r_line;

    // Moving to a new angle always restarts the line count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_angle <= '0;
            r_line  <= '0;
        end else if (clear) begin
            r_angle <= '0;
            r_line  <= '0;
        end else if (angle_inc) begin
            r_angle <= r_angle + 1'b1;
            r_line  <= '0;
        end else if (line_inc) begin
            r_line  <= r_line + 1'b1;
        end
    end

    assign angle      = r_angle;
    assign line       = r_line;
    assign line_last  = (r_line == c_line_last);
    assign angle_last = (r_angle == c_angle_last);

endmodule

`default_nettype wire

// File: rtl/nabp_line_sequencer.sv
// ============================================================================
// nabp_line_sequencer : walks angles x lines, kicking the NABP shifter
// Revision: 1.0
// ============================================================================
`default_nettype none

module nabp_line_sequencer
    import nabp_line_sequencer_pkg::*;
#(
    parameter int IMAGE_SIZE   = c_image_size_default,
    parameter int NO_OF_ANGLES = c_no_of_angles_default,
    parameter int ANGLE_WIDTH  = c_angle_width_default,
    parameter int LINE_WIDTH   = c_line_width_default,
    parameter int ACCU_WIDTH   = c_accu_width_default
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   hs_kick,
    output logic                   hs_busy,
    output logic                   hs_done,
    output logic [ANGLE_WIDTH-1:0] lut_angle,
    input  logic [ACCU_WIDTH-1:0]  lut_accu_base,
    output logic                   sh_fill_kick,
    output logic                   sh_shift_kick,
    output logic [ACCU_WIDTH-1:0]  sh_accu_base,
    input  logic                   sh_fill_done,
    input  logic                   sh_shift_done,
    input  logic                   ds_stall,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic [LINE_WIDTH-1:0]  line,
    output logic                   angle_kick
);

    logic [c_state_width-1:0] r_state;
    logic [ACCU_WIDTH-1:0]    r_accu_base;
    logic                     r_shift_kick;
    logic                     w_clear;
    logic                     w_line_inc;
    logic                     w_angle_inc;
    logic                     w_line_last;
    logic                     w_angle_last;

    assign w_clear     = (r_state == c_st_ready) && hs_kick;
    assign w_line_inc  = (r_state == c_st_advance) && !w_line_last;
    assign w_angle_inc = (r_state == c_st_advance) && w_line_last && !w_angle_last;

    nabp_line_sequencer_counters #(
        .IMAGE_SIZE   (IMAGE_SIZE),
        .NO_OF_ANGLES (NO_OF_ANGLES),
        .ANGLE_WIDTH  (ANGLE_WIDTH),
        .LINE_WIDTH   (LINE_WIDTH)
    ) u_counters (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (w_clear),
        .line_inc   (w_line_inc),
        .angle_inc  (w_angle_inc),
        .angle      (angle),
        .line       (line),
        .line_last  (w_line_last),
        .angle_last (w_angle_last)
    );

    // Shift kick is registered so ds_stall never reaches the kick combinationally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_st_ready;
            r_accu_base  <= '0;
            r_shift_kick <= 1'b0;
        end else begin
            r_shift_kick <= 1'b0;
            case (r_state)
                c_st_ready:      if (hs_kick) r_state <= c_st_lookup;
                c_st_lookup:     r_state <= c_st_latch;
                c_st_latch: begin
                    r_accu_base <= lut_accu_base;
                    r_state     <= c_st_fill;
                end
                c_st_fill:       r_state <= c_st_fill_wait;
                c_st_fill_wait:  if (sh_fill_done) r_state <= c_st_shift_arm;
                c_st_shift_arm: begin
                    if (!ds_stall) begin
                        r_shift_kick <= 1'b1;
                        r_state      <= c_st_shift_wait;
                    end
                end
                c_st_shift_wait: if (sh_shift_done) r_state <= c_st_advance;
                c_st_advance: begin
                    if (!w_line_last)       r_state <= c_st_fill;
                    else if (!w_angle_last) r_state <= c_st_lookup;
                    else                    r_state <= c_st_done;
                end
                c_st_done:       r_state <= c_st_ready;
                default:         r_state <= c_st_ready;
            endcase
        end
    end

    // The LUT address tracks the angle counter; the LUT answers one cycle later
    assign lut_angle     = angle;
    assign sh_accu_base  = r_accu_base;
    assign sh_shift_kick = r_shift_kick;
    assign sh_fill_kick  = (r_state == c_st_fill);
    assign angle_kick    = (r_state == c_st_latch);
    assign hs_done       = (r_state == c_st_done);
    assign hs_busy       = (r_state != c_st_ready) && (r_state != c_st_done);

endmodule

`default_nettype wire

// File: tb/tb_nabp_line_sequencer.sv
// ============================================================================
// tb_nabp_line_sequencer : frame-level scoreboard bench with scenario table
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nabp_line_sequencer;

    localparam int IMG    = 4;
    localparam int NANG   = 3;
    localparam int AW     = 8;
    localparam int LW     = 7;
    localparam int ACW    = 16;
    localparam int LAT    = 5;
    localparam int MAXCYC = 3000;

    logic           clk;
    logic           reset_n;
    logic           hs_kick;
    logic           hs_busy;
    logic           hs_done;
    logic [AW-1:0]  lut_angle;
    logic [ACW-1:0] lut_accu_base;
    logic           sh_fill_kick;
    logic           sh_shift_kick;
    logic [ACW-1:0] sh_accu_base;
    logic           sh_fill_done;
    logic           sh_shift_done;
    logic           ds_stall;
    logic [AW-1:0]  angle;
    logic [LW-1:0]  line;
    logic           angle_kick;

    nabp_line_sequencer #(
        .IMAGE_SIZE   (IMG),
        .NO_OF_ANGLES (NANG),
        .ANGLE_WIDTH  (AW),
        .LINE_WIDTH   (LW),
        .ACCU_WIDTH   (ACW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .hs_kick       (hs_kick),
        .hs_busy       (hs_busy),
        .hs_done       (hs_done),
        .lut_angle     (lut_angle),
        .lut_accu_base (lut_accu_base),
        .sh_fill_kick  (sh_fill_kick),
        .sh_shift_kick (sh_shift_kick),
        .sh_accu_base  (sh_accu_base),
        .sh_fill_done  (sh_fill_done),
        .sh_shift_done (sh_shift_done),
        .ds_stall      (ds_stall),
        .angle         (angle),
        .line          (line),
        .angle_kick    (angle_kick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Angle LUT with one cycle of read latency
    always @(posedge clk) lut_accu_base <= 16'h0100 + ACW'(lut_angle);

    typedef struct packed {
        logic [AW-1:0]  a;
        logic [LW-1:0]  l;
        logic [ACW-1:0] accu;
    } sb_t;

    typedef struct {
        bit stall;
        bit spur;
        bit rekick;
        int exp_fill;
        int exp_shift;
        int exp_akick;
        int exp_done;
    } vec_t;

    sb_t  sb_q[$];
    sb_t  cur;
    vec_t vecs[5];

    int checks = 0;
    int failures = 0;

    int cyc, fill_cnt, shift_cnt, spur_cnt, stall_cnt, drop_cyc, kick_delay;
    int n_fill, n_shift, n_akick, n_done, order_viol, stall_viol;
    bit row_stall, row_spur, stall_used, await_kick, fill_done_seen, target_hit;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Shifter/downstream model plus output monitor, all on the falling edge
    initial begin
        sh_fill_done = 1'b0; sh_shift_done = 1'b0; ds_stall = 1'b0;
        cyc = 0; fill_cnt = 0; shift_cnt = 0; spur_cnt = 0; stall_cnt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                fill_cnt = 0; shift_cnt = 0; spur_cnt = 0; stall_cnt = 0;
                sh_fill_done = 1'b0; sh_shift_done = 1'b0; ds_stall = 1'b0;
                continue;
            end
            if (sh_fill_done) fill_done_seen = 1'b1;
            if (sh_fill_kick) begin
                n_fill++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_fill", 64'(n_fill), 64'(0));
                end else begin
                    cur = sb_q.pop_front();
                    check("fill_angle", 64'(angle), 64'(cur.a));
                    check("fill_line", 64'(line), 64'(cur.l));
                    check("fill_accu", 64'(sh_accu_base), 64'(cur.accu));
                end
                fill_done_seen = 1'b0;
                fill_cnt = LAT;
                if (row_spur) spur_cnt = 2;
            end
            if (sh_shift_kick) begin
                n_shift++;
                if (!fill_done_seen) order_viol++;
                if (ds_stall) stall_viol++;
                if (await_kick) begin
                    kick_delay = cyc - drop_cyc;
                    await_kick = 1'b0;
                end
                check("shift_accu_stable", 64'(sh_accu_base), 64'(cur.accu));
                if (angle == 1 && line == 2) target_hit = 1'b1;
                shift_cnt = LAT;
            end
            if (angle_kick) n_akick++;
            if (hs_done) begin
                n_done++;
                check("busy_at_done", 64'(hs_busy), 64'(0));
            end
            if (row_stall && !stall_used && fill_cnt == 1 && angle == 1 && line == 1) begin
                ds_stall = 1'b1; stall_cnt = 10; stall_used = 1'b1;
            end else if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) begin
                    ds_stall = 1'b0; drop_cyc = cyc; await_kick = 1'b1;
                end
            end
            sh_fill_done  = (fill_cnt == 1);
            sh_shift_done = (shift_cnt == 1) || (spur_cnt == 1);
            if (fill_cnt > 0)  fill_cnt--;
            if (shift_cnt > 0) shift_cnt--;
            if (spur_cnt > 0)  spur_cnt--;
        end
    end

    task automatic clear_tallies();
        sb_t e;
        n_fill = 0; n_shift = 0; n_akick = 0; n_done = 0;
        order_viol = 0; stall_viol = 0; kick_delay = -1;
        stall_used = 1'b0; await_kick = 1'b0; target_hit = 1'b0; fill_done_seen = 1'b0;
        sb_q.delete();
        for (int a = 0; a < NANG; a++) begin
            for (int l = 0; l < IMG; l++) begin
                e.a = AW'(a); e.l = LW'(l); e.accu = 16'h0100 + ACW'(a);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_kick();
        @(negedge clk); #1 hs_kick = 1'b1;
        @(negedge clk); #1 hs_kick = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < MAXCYC; c++) begin
            @(negedge clk); #1;
            if (n_done > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_frame(input vec_t v);
        bit ok;
        row_stall = v.stall; row_spur = v.spur;
        clear_tallies();
        pulse_kick();
        if (v.rekick) begin
            repeat (40) @(negedge clk);
            #1 check("busy_mid_frame", 64'(hs_busy), 64'(1));
            hs_kick = 1'b1;
            @(negedge clk); #1 hs_kick = 1'b0;
        end
        wait_done(ok);
        check("done_timeout", 64'(ok), 64'(1));
        repeat (5) @(negedge clk);
        #1;
        check("fill_kicks", 64'(n_fill), 64'(v.exp_fill));
        check("shift_kicks", 64'(n_shift), 64'(v.exp_shift));
        check("angle_kicks", 64'(n_akick), 64'(v.exp_akick));
        check("done_pulses", 64'(n_done), 64'(v.exp_done));
        check("busy_after_done", 64'(hs_busy), 64'(0));
        check("sb_leftover", 64'(sb_q.size()), 64'(0));
        check("shift_before_fill_done", 64'(order_viol), 64'(0));
        if (v.stall) begin
            check("kick_during_stall", 64'(stall_viol), 64'(0));
            check("kick_after_stall_delay", 64'(kick_delay), 64'(1));
        end
    endtask

    initial begin
        bit ok;
        reset_n = 1'b0; hs_kick = 1'b0;
        row_stall = 1'b0; row_spur = 1'b0;
        //            stall spur rekick fill shift akick done
        vecs[0] = '{1'b0, 1'b0, 1'b0, 12, 12, 3, 1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 12, 12, 3, 1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 12, 12, 3, 1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 12, 12, 3, 1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 12, 12, 3, 1};
        clear_tallies();

        repeat (3) @(negedge clk);
        #1 check("reset_outputs",
                 64'({hs_busy, hs_done, sh_fill_kick, sh_shift_kick, angle_kick,
                      angle, line, lut_angle, sh_accu_base}), 64'(0));
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("idle_after_reset", 64'({hs_busy, sh_fill_kick, angle_kick}), 64'(0));

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Asynchronous reset while waiting for the shift of angle 1, line 2
        row_stall = 1'b0; row_spur = 1'b0;
        clear_tallies();
        pulse_kick();
        for (int c = 0; c < MAXCYC; c++) begin
            @(negedge clk); #1;
            if (target_hit) break;
        end
        check("reach_a1_l2", 64'(target_hit), 64'(1));
        check("pre_reset_angle", 64'(angle), 64'(1));
        reset_n = 1'b0;
        #1 check("async_reset_outputs",
                 64'({hs_busy, hs_done, sh_fill_kick, sh_shift_kick, angle_kick,
                      angle, line, lut_angle, sh_accu_base}), 64'(0));
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        clear_tallies();
        pulse_kick();
        wait_done(ok);
        check("restart_done", 64'(ok), 64'(1));
        repeat (3) @(negedge clk);
        #1;
        check("restart_fill_kicks", 64'(n_fill), 64'(12));
        check("restart_shift_kicks", 64'(n_shift), 64'(12));
        check("restart_sb_leftover", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
